potato_timer: RTL and testbench

Countdown-timer control stage for the potato game screen. It turns five debounced push-button levels into an editable MM:SS preset, runs a 1 Hz countdown, and flags expiry. Its digit and cursor outputs drive the potato display memory stage directly: `minute2`, `minute1`, `second2`, `second1`, `select`.

---
 rtl/potato_pkg.sv | 34 +++
 rtl/potato_btn_edge.sv | 18 +
 rtl/potato_timer.sv | 151 +++++++++++++++
 tb/tb_potato_timer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/potato_pkg.sv
// Shared types, cursor codes and digit helpers for the potato countdown timer.
package potato_pkg;

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned DIGIT_W = 5;

  localparam logic [DIGIT_W-1:0] SEL_SEC1  = 5'd0;
  localparam logic [DIGIT_W-1:0] SEL_SEC2  = 5'd1;
  localparam logic [DIGIT_W-1:0] SEL_MIN1  = 5'd2;
  localparam logic [DIGIT_W-1:0] SEL_MIN2  = 5'd3;
  localparam logic [DIGIT_W-1:0] SEL_COLON = 5'd4;
  localparam logic [DIGIT_W-1:0] SEL_NONE  = 5'd7;

  localparam logic [DIGIT_W-1:0] TENS_MAX = 5'd5;
  localparam logic [DIGIT_W-1:0] ONES_MAX = 5'd9;

  // Single-digit increment/decrement wrapping between 0 and lim.
  function automatic logic [DIGIT_W-1:0] inc_wrap(input logic [DIGIT_W-1:0] d,
                                                  input logic [DIGIT_W-1:0] lim);
    return (d >= lim) ? 5'd0 : d + 5'd1;
  endfunction

  function automatic logic [DIGIT_W-1:0] dec_wrap(input logic [DIGIT_W-1:0] d,
                                                  input logic [DIGIT_W-1:0] lim);
    return (d == 5'd0) ? lim : d - 5'd1;
  endfunction

endpackage

// File: rtl/potato_btn_edge.sv
// Rising-edge detector for the five debounced button levels.
module potato_btn_edge (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn,
  output logic [4:0] rise_c
);

  logic [4:0] prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev <= '0;
    else      prev <= btn;
  end

  assign rise_c = btn & ~prev;

endmodule

// File: rtl/potato_timer.sv
// MM:SS preset editor, 1 Hz countdown and expiry flag for the potato game screen.
module potato_timer
  import potato_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_center,
  output logic [4:0] minute2,
  output logic [4:0] minute1,
  output logic [4:0] second2,
  output logic [4:0] second1,
  output logic [4:0] select,
  output logic       running,
  output logic       done
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        state;
  logic [PW-1:0] presc;
  logic [4:0]    pre_m2, pre_m1, pre_s2, pre_s1;
  logic [4:0]    rise;

  potato_btn_edge u_edge (
    .clk    (clk),
    .rst    (rst),
    .btn    ({btn_center, btn_down, btn_up, btn_right, btn_left}),
    .rise_c (rise)
  );

  // Resolve simultaneous edges to a single action: center > left > right > up > down.
  logic act_center, act_left, act_right, act_up, act_down;
  always_comb begin
    act_center = rise[4];
    act_left   = rise[0] & ~rise[4];
    act_right  = rise[1] & ~rise[4] & ~rise[0];
    act_up     = rise[2] & ~rise[4] & ~|rise[1:0];
    act_down   = rise[3] & ~rise[4] & ~|rise[2:0];
  end

  logic tick, last_sec, time_zero;
  assign tick      = (presc == PRESC_LAST);
  assign time_zero = ({minute2, minute1, second2, second1} == 20'd0);
  assign last_sec  = ({minute2, minute1, second2} == 15'd0) && (second1 == 5'd1);

  // One-second decrement with borrow from the ones of seconds up to the tens of minutes.
  logic [4:0] dec_m2, dec_m1, dec_s2, dec_s1;
  always_comb begin
    dec_m2 = minute2;
    dec_m1 = minute1;
    dec_s2 = second2;
    dec_s1 = second1 - 5'd1;
    if (second1 == 5'd0) begin
      dec_s1 = ONES_MAX;
      dec_s2 = second2 - 5'd1;
      if (second2 == 5'd0) begin
        dec_s2 = TENS_MAX;
        dec_m1 = minute1 - 5'd1;
        if (minute1 == 5'd0) begin
          dec_m1 = ONES_MAX;
          dec_m2 = minute2 - 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_SET;
      presc   <= '0;
      minute2 <= '0;
      minute1 <= '0;
      second2 <= '0;
      second1 <= '0;
      pre_m2  <= '0;
      pre_m1  <= '0;
      pre_s2  <= '0;
      pre_s1  <= '0;
      select  <= SEL_SEC1;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_SET: begin
          if (act_center) begin
            if (select == SEL_COLON && !time_zero) begin
              {pre_m2, pre_m1, pre_s2, pre_s1} <= {minute2, minute1, second2, second1};
              presc   <= '0;
              state   <= ST_RUN;
              select  <= SEL_NONE;
              running <= 1'b1;
            end
          end else if (act_left) begin
            select <= (select == SEL_SEC1) ? SEL_COLON : select - 5'd1;
          end else if (act_right) begin
            select <= (select == SEL_COLON) ? SEL_SEC1 : select + 5'd1;
          end else if (act_up || act_down) begin
            case (select)
              SEL_SEC1: second1 <= act_up ? inc_wrap(second1, ONES_MAX) : dec_wrap(second1, ONES_MAX);
              SEL_SEC2: second2 <= act_up ? inc_wrap(second2, TENS_MAX) : dec_wrap(second2, TENS_MAX);
              SEL_MIN1: minute1 <= act_up ? inc_wrap(minute1, ONES_MAX) : dec_wrap(minute1, ONES_MAX);
              SEL_MIN2: minute2 <= act_up ? inc_wrap(minute2, TENS_MAX) : dec_wrap(minute2, TENS_MAX);
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          presc <= tick ? '0 : presc + PW'(1);
          if (tick) {minute2, minute1, second2, second1} <= {dec_m2, dec_m1, dec_s2, dec_s1};
          // Expiry outranks a simultaneous pause request.
          if (tick && last_sec) begin
            state   <= ST_DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (act_center) begin
            state   <= ST_PAUSE;
            running <= 1'b0;
            select  <= SEL_COLON;
          end
        end
        ST_PAUSE: begin
          if (act_center) begin
            state   <= ST_RUN;
            running <= 1'b1;
            select  <= SEL_NONE;
          end else if (act_down) begin
            state  <= ST_SET;
            select <= SEL_SEC1;
          end
        end
        ST_DONE: begin
          if (act_center) begin
            {minute2, minute1, second2, second1} <= {pre_m2, pre_m1, pre_s2, pre_s1};
            state  <= ST_SET;
            select <= SEL_COLON;
            done   <= 1'b0;
          end
        end
        default: state <= ST_SET;
      endcase
    end
  end

endmodule

// File: tb/tb_potato_timer.sv
// Randomized and directed checks of potato_timer against a seconds-based reference model.
`timescale 1ns/1ps
module tb_potato_timer;

  localparam int TICK = 4;
  localparam logic [4:0] B_L = 5'd1, B_R = 5'd2, B_U = 5'd4, B_D = 5'd8, B_C = 5'd16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] btn = '0;
  logic [4:0] minute2, minute1, second2, second1, select;
  logic running, done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  potato_timer #(.TICK_DIV(TICK)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_left   (btn[0]),
    .btn_right  (btn[1]),
    .btn_up     (btn[2]),
    .btn_down   (btn[3]),
    .btn_center (btn[4]),
    .minute2    (minute2),
    .minute1    (minute1),
    .second2    (second2),
    .second1    (second1),
    .select     (select),
    .running    (running),
    .done       (done)
  );

  // Reference model: digit index equals cursor code (0=s1,1=s2,2=m1,3=m2).
  int ms;            // 0 set, 1 run, 2 pause, 3 done
  int cur;
  int d[4];
  int pre[4];
  int frac;
  logic [4:0] prev;

  function automatic int lim(input int i);
    return (i % 2 == 1) ? 6 : 10;
  endfunction

  function automatic int secs();
    return d[3] * 600 + d[2] * 60 + d[1] * 10 + d[0];
  endfunction

  task automatic set_secs(input int s);
    d[3] = s / 600;
    d[2] = (s / 60) % 10;
    d[1] = (s % 60) / 10;
    d[0] = s % 10;
  endtask

  task automatic model_reset();
    ms = 0; cur = 0; frac = 0; prev = '0;
    for (int i = 0; i < 4; i++) begin d[i] = 0; pre[i] = 0; end
  endtask

  task automatic model_step(input logic [4:0] b);
    logic [4:0] r;
    int act;
    r = b & ~prev;
    prev = b;
    act = -1;
    if (r[4]) act = 4;
    else for (int i = 3; i >= 0; i--) if (r[i]) act = i;
    case (ms)
      0: begin
        if (act == 4) begin
          if (cur == 4 && secs() != 0) begin
            pre = d; frac = 0; ms = 1;
          end
        end else if (act == 0) cur = (cur + 4) % 5;
        else if (act == 1) cur = (cur + 1) % 5;
        else if (act == 2 && cur < 4) d[cur] = (d[cur] + 1) % lim(cur);
        else if (act == 3 && cur < 4) d[cur] = (d[cur] + lim(cur) - 1) % lim(cur);
      end
      1: begin
        frac++;
        if (frac == TICK) begin
          frac = 0;
          set_secs(secs() - 1);
          if (secs() == 0) ms = 3;
          else if (act == 4) ms = 2;
        end else if (act == 4) ms = 2;
      end
      2: begin
        if (act == 4) ms = 1;
        else if (act == 3) begin ms = 0; cur = 0; end
      end
      default: begin
        if (act == 4) begin d = pre; ms = 0; cur = 4; end
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int dut_time();
    return int'(minute2) * 1000 + int'(minute1) * 100 + int'(second2) * 10 + int'(second1);
  endfunction

  task automatic compare_all(input string tag);
    int exp_sel;
    exp_sel = (ms == 0) ? cur : (ms == 2) ? 4 : 7;
    check({tag, "_time"}, 32'(dut_time()), 32'(d[3] * 1000 + d[2] * 100 + d[1] * 10 + d[0]));
    check({tag, "_sel"}, 32'(select), 32'(exp_sel));
    check({tag, "_run"}, 32'(running), 32'(ms == 1));
    check({tag, "_done"}, 32'(done), 32'(ms == 3));
  endtask

  task automatic cycle(input logic [4:0] b);
    btn = b;
    model_step(b);
    @(posedge clk);
    @(negedge clk);
    compare_all("cyc");
  endtask

  task automatic press(input logic [4:0] b);
    cycle(b);
    cycle('0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    btn = '0;
    rst = 1'b0;
    model_reset();
    #1;
    compare_all("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int exp_sel[5];
    logic [4:0] b;
    int r;
    exp_sel = '{1, 2, 3, 4, 0};
    model_reset();

    // Cursor stepping and held button.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cycle(B_R);
      check("sel_right", 32'(select), 32'(exp_sel[k]));
      cycle('0);
    end
    cycle(B_L);
    check("sel_left_wrap", 32'(select), 32'd4);
    cycle('0);
    for (int k = 0; k < 10; k++) cycle(B_R);
    check("sel_hold", 32'(select), 32'd0);
    cycle('0);

    // Digit wrap without carry.
    do_reset();
    press(B_R);
    press(B_D);
    check("s2_wrap_down", 32'(second2), 32'd5);
    press(B_L);
    for (int k = 0; k < 10; k++) press(B_U);
    check("s1_wrap_up", 32'(second1), 32'd0);
    check("s1_wrap_time", 32'(dut_time()), 32'd50);

    // 01:00 countdown to expiry.
    do_reset();
    press(B_R); press(B_R); press(B_U); press(B_R); press(B_R);
    cycle(B_C);
    check("start_running", 32'(running), 32'd1);
    for (int k = 0; k < 4; k++) cycle('0);
    check("first_dec", 32'(dut_time()), 32'd59);
    for (int k = 0; k < 236; k++) cycle('0);
    check("expire_time", 32'(dut_time()), 32'd0);
    check("expire_done", 32'(done), 32'd1);
    check("expire_run", 32'(running), 32'd0);

    // 00:03 with pause/resume, expiry, reload and async reset mid-run.
    do_reset();
    press(B_U); press(B_U); press(B_U); press(B_L);
    cycle(B_C);
    for (int k = 0; k < 5; k++) cycle('0);
    cycle(B_C);
    check("pause_time", 32'(dut_time()), 32'd2);
    check("pause_sel", 32'(select), 32'd4);
    for (int k = 0; k < 20; k++) cycle('0);
    check("paused_frozen", 32'(dut_time()), 32'd2);
    cycle(B_C);
    check("resume_run", 32'(running), 32'd1);
    cycle('0);
    check("resume_r1", 32'(dut_time()), 32'd2);
    cycle('0);
    check("resume_r2", 32'(dut_time()), 32'd1);
    for (int k = 0; k < 4; k++) cycle('0);
    check("done2", 32'(done), 32'd1);
    cycle(B_C);
    check("reload_time", 32'(dut_time()), 32'd3);
    check("reload_sel", 32'(select), 32'd4);
    check("reload_done", 32'(done), 32'd0);
    cycle('0);
    cycle(B_C);
    cycle('0);
    cycle('0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("async_time", 32'(dut_time()), 32'd0);
    check("async_sel", 32'(select), 32'd0);
    check("async_run", 32'(running), 32'd0);
    check("async_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Simultaneous center+up, and center on 00:00.
    do_reset();
    press(B_R); press(B_R);
    cycle(B_C | B_U);
    check("cu_time", 32'(dut_time()), 32'd0);
    check("cu_sel", 32'(select), 32'd2);
    cycle('0);
    press(B_R); press(B_R);
    cycle(B_C);
    check("zero_start_run", 32'(running), 32'd0);
    check("zero_start_sel", 32'(select), 32'd4);
    cycle('0);

    // Random button traffic.
    do_reset();
    b = '0;
    for (int k = 0; k < 3000; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5) b = '0;
      else if (r < 8) b = 5'(1 << $urandom_range(0, 4));
      else if (r < 9) b = 5'($urandom);
      cycle(b);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
